scoreboard_digit_scheduler: RTL and testbench

- Sequences one shared digit-glyph ROM across DIGITS score positions on the scoreboard.
- Accepts a binary score from game logic and converts it to BCD once per frame with a sequential double-dabble.
- During the scoreboard raster window, generates the glyph ROM address and read enable for each digit slot.
- Sits between game-state logic and the glyph ROM, beside the other sprite controllers in the pixel pipeline.

---
 rtl/scoreboard_digit_scheduler_pkg.sv | 42 ++++
 rtl/scoreboard_digit_scheduler_if.sv | 27 ++
 rtl/scoreboard_digit_scheduler_bin2bcd_seq.sv | 83 ++++++++
 rtl/scoreboard_digit_scheduler.sv | 117 +++++++++++
 tb/tb_scoreboard_digit_scheduler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_digit_scheduler_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the scoreboard digit scheduler.
// Raster constants fall back to local defaults when the shared define file is not in the build.
`ifndef CORDW
`define CORDW 10
`endif
`ifndef SCORE_Y
`define SCORE_Y 32
`endif
`ifndef GLYPH_ROM_AW
`define GLYPH_ROM_AW 12
`endif

package scoreboard_digit_scheduler_pkg;

  localparam int CORDW        = `CORDW;
  localparam int SCORE_Y      = `SCORE_Y;
  localparam int GLYPH_ROM_AW = `GLYPH_ROM_AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } b2b_state_e;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Upper bound on decimal digits needed for a binary value of the given width.
  function automatic int bcd_nibbles(input int bits);
    return (bits + 2) / 3;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scoreboard_digit_scheduler_if.sv
// Score, raster position and glyph ROM fetch signals of the scoreboard digit scheduler.
interface scoreboard_digit_scheduler_if #(
  parameter int DIGITS     = 4,
  parameter int SCORE_BITS = 14
);
  import scoreboard_digit_scheduler_pkg::*;

  logic [CORDW-1:0]        pixel;
  logic [CORDW-1:0]        line;
  logic [SCORE_BITS-1:0]   score;
  logic                    score_valid;
  logic [GLYPH_ROM_AW-1:0] rom_addr;
  logic                    rom_rden;
  logic [4*DIGITS-1:0]     digits_bcd;
  logic                    busy;

  modport master (
    output pixel, line, score, score_valid,
    input  rom_addr, rom_rden, digits_bcd, busy
  );

  modport slave (
    input  pixel, line, score, score_valid,
    output rom_addr, rom_rden, digits_bcd, busy
  );

endinterface

// File: rtl/scoreboard_digit_scheduler_bin2bcd_seq.sv
// Sequential double-dabble: start -> LOAD, SCORE_BITS x SHIFT, COMMIT (done pulse, bcd_o valid).
// Values above 10^DIGITS-1 saturate to all nines; the check is made while loading.
module scoreboard_digit_scheduler_bin2bcd_seq
  import scoreboard_digit_scheduler_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCORE_BITS = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [SCORE_BITS-1:0] bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int ACC_N = imax(bcd_nibbles(SCORE_BITS), DIGITS);
  localparam int ACC_W = 4 * ACC_N;
  localparam int CNT_W = $clog2(SCORE_BITS + 1);
  localparam logic [31:0] SAT_LIM = 32'(pow10(DIGITS) - 1);

  b2b_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [SCORE_BITS-1:0]   bin_sh_q, bin_step;
  logic [ACC_W-1:0]        acc_q, acc_adj, acc_step;
  logic                    sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_q == CNT_W'(SCORE_BITS - 1)) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE);
    done_o = (state_q == ST_COMMIT);
    bcd_o  = sat_q ? {DIGITS{4'h9}} : acc_q[4*DIGITS-1:0];
  end

  always_comb begin
    acc_adj = acc_q;
    for (int n = 0; n < ACC_N; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
    end
    {acc_step, bin_step} = {acc_adj, bin_sh_q} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bin_sh_q <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          cnt_q    <= '0;
          bin_sh_q <= bin_i;
          acc_q    <= '0;
          sat_q    <= (32'(bin_i) > SAT_LIM);
        end
        ST_SHIFT: begin
          cnt_q    <= cnt_q + CNT_W'(1);
          bin_sh_q <= bin_step;
          acc_q    <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/scoreboard_digit_scheduler.sv
// Converts the latest score to BCD once per frame and drives glyph ROM fetches for each digit slot.
// Define SCORE_LZB_EN to blank leading-zero slots (the last slot is always drawn).
module scoreboard_digit_scheduler
  import scoreboard_digit_scheduler_pkg::*;
#(
  parameter int SPR_X      = 400,
  parameter int DIGITS     = 4,
  parameter int GLYPH_W    = 16,
  parameter int GLYPH_H    = 16,
  parameter int SCORE_BITS = 14
) (
  input logic                         clk,
  input logic                         rst_n,
  scoreboard_digit_scheduler_if.slave sb
);

  localparam int C1     = CORDW + 1;
  localparam int LOG_W  = $clog2(GLYPH_W);
  localparam int LOG_H  = $clog2(GLYPH_H);
  localparam int SLOT_W = 3;
  localparam int SC_W   = SLOT_W + LOG_W;
  localparam int GA_W   = 4 + LOG_H + LOG_W;
  // Window leads the drawn sprite by two cycles: our register plus the ROM output register.
  localparam logic [C1-1:0] X_LO = C1'(SPR_X - 2);
  localparam logic [C1-1:0] X_HI = C1'(SPR_X + DIGITS * GLYPH_W - 3);
  localparam logic [C1-1:0] Y_LO = C1'(SCORE_Y);
  localparam logic [C1-1:0] Y_HI = C1'(SCORE_Y + GLYPH_H);

  logic [SCORE_BITS-1:0]   pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0]     digits_q, digits_d, bcd_res;
  logic [GLYPH_ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic                    rom_rden_q, rom_rden_d;
  logic                    frame_start, start, conv_busy, conv_done;
  logic [C1-1:0]           px, ln;
  logic                    in_win;
  logic [SC_W-1:0]         slot_col;
  logic [SLOT_W-1:0]       slot;
  logic [LOG_W-1:0]        col;
  logic [LOG_H-1:0]        row;
  logic [3:0]              dig;
  logic [GA_W-1:0]         glyph_addr;

  assign frame_start = (sb.pixel == '0) && (sb.line == '0);
  assign start       = frame_start && (pend_vld_q || sb.score_valid) && !conv_busy;
  assign pend_d      = sb.score_valid ? sb.score : pend_q;
  assign pend_vld_d  = start ? 1'b0 : (sb.score_valid ? 1'b1 : pend_vld_q);
  assign digits_d    = conv_done ? bcd_res : digits_q;

  // LOAD samples pend_q one cycle after start, so a strobe on the frame-start cycle is included.
  scoreboard_digit_scheduler_bin2bcd_seq #(
    .DIGITS     (DIGITS),
    .SCORE_BITS (SCORE_BITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .bin_i   (pend_q),
    .bcd_o   (bcd_res),
    .busy_o  (conv_busy),
    .done_o  (conv_done)
  );

  always_comb begin
    px       = {1'b0, sb.pixel};
    ln       = {1'b0, sb.line};
    in_win   = (px >= X_LO) && (px <= X_HI) && (ln >= Y_LO) && (ln < Y_HI);
    slot_col = SC_W'(px - X_LO);
    slot     = slot_col[SC_W-1 -: SLOT_W];
    col      = slot_col[LOG_W-1:0];
    row      = LOG_H'(ln - Y_LO);
    dig      = 4'd0;
    for (int s = 0; s < DIGITS; s++) begin
      if (slot == SLOT_W'(s)) dig = digits_q[4*(DIGITS-1-s) +: 4];
    end
    glyph_addr = {dig, row, col};
    rom_addr_d = in_win ? GLYPH_ROM_AW'(glyph_addr) : rom_addr_q;
  end

`ifdef SCORE_LZB_EN
  logic seen_nz, blank;

  always_comb begin
    seen_nz = 1'b0;
    blank   = 1'b0;
    for (int s = 0; s < DIGITS; s++) begin
      if (digits_q[4*(DIGITS-1-s) +: 4] != 4'd0) seen_nz = 1'b1;
      if (slot == SLOT_W'(s)) blank = !seen_nz && (s != DIGITS - 1);
    end
    rom_rden_d = in_win && !blank;
  end
`else
  assign rom_rden_d = in_win;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      digits_q   <= '0;
      rom_addr_q <= '0;
      rom_rden_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      digits_q   <= digits_d;
      rom_addr_q <= rom_addr_d;
      rom_rden_q <= rom_rden_d;
    end
  end

  assign sb.rom_addr   = rom_addr_q;
  assign sb.rom_rden   = rom_rden_q;
  assign sb.digits_bcd = digits_q;
  assign sb.busy       = conv_busy;

endmodule

// File: tb/tb_scoreboard_digit_scheduler.sv
// Directed bench for scoreboard_digit_scheduler; leading-zero expectations follow SCORE_LZB_EN.
module tb_scoreboard_digit_scheduler;
  import scoreboard_digit_scheduler_pkg::*;

  localparam int SPR_X  = 400;
  localparam int DIGITS = 4;
  localparam int SB     = 14;
  localparam int ROW3   = SCORE_Y + 3;
`ifdef SCORE_LZB_EN
  localparam logic [31:0] EXP_LZ_RDEN = 32'd0;
`else
  localparam logic [31:0] EXP_LZ_RDEN = 32'd1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scoreboard_digit_scheduler_if #(.DIGITS(DIGITS), .SCORE_BITS(SB)) sb ();

  scoreboard_digit_scheduler #(
    .SPR_X      (SPR_X),
    .DIGITS     (DIGITS),
    .GLYPH_W    (16),
    .GLYPH_H    (16),
    .SCORE_BITS (SB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_pos();
    sb.pixel = 10'd100;
    sb.line  = 10'd200;
  endtask

  task automatic strobe(input int v);
    sb.score       = SB'(v);
    sb.score_valid = 1'b1;
    tick();
    sb.score_valid = 1'b0;
  endtask

  task automatic frame();
    sb.pixel = '0;
    sb.line  = '0;
    tick();
    idle_pos();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sb.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb.busy), 32'd0);
  endtask

  task automatic fetch(input int px, input int ln);
    sb.pixel = 10'(px);
    sb.line  = 10'(ln);
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    sb.score       = '0;
    sb.score_valid = 1'b0;
    idle_pos();
    tick();
    tick();
    chk("rst_addr", 32'(sb.rom_addr), 32'd0);
    chk("rst_rden", 32'(sb.rom_rden), 32'd0);
    chk("rst_digits", 32'(sb.digits_bcd), 32'd0);
    chk("rst_busy", 32'(sb.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1234 strobed mid-frame: nothing moves until frame start, then 16 cycles to commit
    strobe(1234);
    tick(); tick(); tick();
    chk("midframe_digits", 32'(sb.digits_bcd), 32'd0);
    chk("midframe_busy", 32'(sb.busy), 32'd0);
    frame();
    chk("load_busy", 32'(sb.busy), 32'd1);
    for (int i = 1; i < 16; i++) tick();
    chk("c15_busy", 32'(sb.busy), 32'd1);
    chk("c15_digits", 32'(sb.digits_bcd), 32'd0);
    tick();
    chk("c16_busy", 32'(sb.busy), 32'd0);
    chk("c16_digits", 32'(sb.digits_bcd), 32'h1234);

    // Address generation, row 3, digits 1234
    fetch(SPR_X - 2, ROW3);
    chk("slot0_rden", 32'(sb.rom_rden), 32'd1);
    chk("slot0_addr", 32'(sb.rom_addr), 32'd304);
    fetch(SPR_X + 13, ROW3);
    chk("slot0_last", 32'(sb.rom_addr), 32'd319);
    fetch(SPR_X + 14, ROW3);
    chk("slot1_first", 32'(sb.rom_addr), 32'd560);
    chk("slot1_rden", 32'(sb.rom_rden), 32'd1);
    fetch(SPR_X + 61, ROW3);
    chk("slot3_last", 32'(sb.rom_addr), 32'd1087);
    fetch(SPR_X + 62, ROW3);
    chk("xhi_out_rden", 32'(sb.rom_rden), 32'd0);
    chk("xhi_out_hold", 32'(sb.rom_addr), 32'd1087);
    fetch(SPR_X - 2, SCORE_Y + 16);
    chk("yhi_out_rden", 32'(sb.rom_rden), 32'd0);
    chk("yhi_out_hold", 32'(sb.rom_addr), 32'd1087);
    fetch(SPR_X - 3, SCORE_Y + 15);
    chk("xlo_out_rden", 32'(sb.rom_rden), 32'd0);
    fetch(SPR_X - 2, SCORE_Y + 15);
    chk("row15_rden", 32'(sb.rom_rden), 32'd1);
    chk("row15_addr", 32'(sb.rom_addr), 32'd496);
    idle_pos();

    // Saturation
    strobe(12000);
    frame();
    wait_idle("sat_done");
    chk("sat_12000", 32'(sb.digits_bcd), 32'h9999);
    strobe(10000);
    frame();
    wait_idle("sat2_done");
    chk("sat_10000", 32'(sb.digits_bcd), 32'h9999);
    strobe(9998);
    frame();
    wait_idle("nosat_done");
    chk("nosat_9998", 32'(sb.digits_bcd), 32'h9998);

    // Latest strobe wins, including one on the frame-start cycle
    strobe(42);
    tick();
    chk("strobe42_hold", 32'(sb.digits_bcd), 32'h9998);
    strobe(77);
    sb.score       = SB'(5);
    sb.score_valid = 1'b1;
    sb.pixel       = '0;
    sb.line        = '0;
    tick();
    sb.score_valid = 1'b0;
    idle_pos();
    wait_idle("coinc_done");
    chk("coinc_5", 32'(sb.digits_bcd), 32'h0005);
    frame();
    chk("no_pending_busy", 32'(sb.busy), 32'd0);

    // Leading zeros with score 7
    strobe(7);
    frame();
    wait_idle("seven_done");
    chk("seven_digits", 32'(sb.digits_bcd), 32'h0007);
    fetch(SPR_X - 2, ROW3);
    chk("lz_slot0_rden", 32'(sb.rom_rden), EXP_LZ_RDEN);
    chk("lz_slot0_addr", 32'(sb.rom_addr), 32'd48);
    fetch(SPR_X + 30, ROW3);
    chk("lz_slot2_rden", 32'(sb.rom_rden), EXP_LZ_RDEN);
    chk("lz_slot2_addr", 32'(sb.rom_addr), 32'd48);
    fetch(SPR_X + 46, ROW3);
    chk("lz_slot3_rden", 32'(sb.rom_rden), 32'd1);
    chk("lz_slot3_addr", 32'(sb.rom_addr), 32'd1840);
    idle_pos();
    tick();

    // Reset on the 5th SHIFT cycle
    strobe(1234);
    frame();
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_busy", 32'(sb.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(sb.busy), 32'd0);
    chk("async_rst_digits", 32'(sb.digits_bcd), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("post_rst_busy", 32'(sb.busy), 32'd0);
    chk("post_rst_digits", 32'(sb.digits_bcd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
